// File: rtl/uart_pkg.sv
// Shared types, parity encodings and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int bit_ticks(input int freq, input int baud);
    return freq / baud;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]                 count_q, count_d;
  logic                        do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    // a full FIFO still takes a push when the head leaves in the same cycle
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: sync, 3-sample vote, frame FSM with error flags,
// and an elastic FIFO presenting a valid/ready byte stream.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int BIT_TICKS = bit_ticks(CLK_FREQUENCY, BAUD_RATE);
  localparam int MID       = BIT_TICKS / 2;
  localparam int TW        = $clog2(BIT_TICKS);
  localparam int BW        = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_S0   = TW'(MID - 1);
  localparam logic [TW-1:0] T_S1   = TW'(MID);
  localparam logic [TW-1:0] T_VOTE = TW'(MID + 1);
  localparam logic [TW-1:0] T_END  = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] IDX_ONE   = BW'(1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);
  localparam logic          PAR_INV   = (PARITY_MODE == PAR_ODD);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_ODD) begin : g_bad_parity
    $error("uart_rx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_param: FIFO_DEPTH must be a power of two >= 2");
  end
  if (BIT_TICKS < 8) begin : g_bad_ticks
    $error("uart_rx_param: CLK_FREQUENCY/BAUD_RATE must be >= 8");
  end

  typedef struct packed {
    logic                 brk;
    logic                 ferr;
    logic                 perr;
    logic [DATA_BITS-1:0] data;
  } rx_entry_t;

  localparam int EW = $bits(rx_entry_t);

  // Reset: asynchronous assert, deassert released through two flops.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  // vld_pipe_q marks when the synchronizer holds real line samples rather
  // than its reset value, so a line stuck low at reset exit never looks like an edge.
  logic       sync1_q, sync2_q, rx_s;
  logic [1:0] vld_pipe_q;
  logic       rx_prev_q, rx_prev_d, fall;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      vld_pipe_q <= '0;
      rx_prev_q  <= 1'b0;
    end else begin
      sync1_q    <= uart_rx;
      sync2_q    <= sync1_q;
      vld_pipe_q <= {vld_pipe_q[0], 1'b1};
      rx_prev_q  <= rx_prev_d;
    end
  end

  assign rx_s      = sync2_q;
  assign rx_prev_d = vld_pipe_q[1] & rx_s;
  assign fall      = rx_prev_q & ~rx_s & vld_pipe_q[1];

  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 ferr_now, vote, vote_pt, end_bit;
  logic                 push;
  rx_entry_t            push_entry, head;

  assign vote_pt = (tick_q == T_VOTE);
  assign end_bit = (tick_q == T_END);
  assign vote    = maj3(samp_q[0], samp_q[1], rx_s);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ferr_now   = ferr_q;
    push       = 1'b0;

    if (state_q != IDLE) begin
      tick_d = end_bit ? '0 : tick_q + T_ONE;
      if (tick_q == T_S0) samp_d[0] = rx_s;
      if (tick_q == T_S1) samp_d[1] = rx_s;
    end

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          tick_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (vote_pt && vote) begin
          state_d = IDLE;
        end else if (end_bit) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (vote_pt) shift_d[bit_idx_q] = vote;
        if (end_bit) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d    = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + IDX_ONE;
          end
        end
      end
      PARITY: begin
        if (vote_pt) perr_d = vote ^ (^shift_q) ^ PAR_INV;
        if (end_bit) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (vote_pt) begin
          ferr_now = ferr_q | ~vote;
          ferr_d   = ferr_now;
          // commit at the last stop vote so a following start edge is not missed
          if (stop_idx_q == LAST_STOP) begin
            push    = 1'b1;
            state_d = ferr_now ? WAIT_HIGH : IDLE;
          end
        end else if (end_bit) begin
          stop_idx_d = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      samp_q     <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.data = shift_q;
    push_entry.perr = perr_q;
    push_entry.ferr = ferr_now;
    push_entry.brk  = ferr_now && (shift_q == '0);
  end

  logic [EW-1:0]                 fifo_rdata;
  logic                          fifo_full, fifo_empty, pop;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overrun_q, overrun_d;

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_int_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pop       = rx_ready && !fifo_empty;
  assign overrun_d = push && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) overrun_q <= 1'b0;
    else            overrun_q <= overrun_d;
  end

  assign head          = rx_entry_t'(fifo_rdata);
  assign rx_data       = head.data;
  assign rx_parity_err = head.perr;
  assign rx_frame_err  = head.ferr;
  assign rx_break      = head.brk;
  assign rx_valid      = (fifo_count != '0);
  assign overrun_err   = overrun_q;
  assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: a frame-level model predicts each delivered
// entry from the bits put on the line; literal checks pin the model.
module tb_uart_rx_param;

  localparam int BT    = 434;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx_d, rx_p, d_rdy, p_rdy;
  logic [7:0] d_data, p_data;
  logic       d_perr, d_ferr, d_brk, d_vld, d_ovr, d_busy;
  logic       p_perr, p_ferr, p_brk, p_vld, p_ovr, p_busy;

  uart_rx_param u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rx       (rx_d),
    .rx_data       (d_data),
    .rx_parity_err (d_perr),
    .rx_frame_err  (d_ferr),
    .rx_break      (d_brk),
    .rx_valid      (d_vld),
    .rx_ready      (d_rdy),
    .overrun_err   (d_ovr),
    .rx_busy       (d_busy)
  );

  uart_rx_param #(.PARITY_MODE(1)) u_par (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rx       (rx_p),
    .rx_data       (p_data),
    .rx_parity_err (p_perr),
    .rx_frame_err  (p_ferr),
    .rx_break      (p_brk),
    .rx_valid      (p_vld),
    .rx_ready      (p_rdy),
    .overrun_err   (p_ovr),
    .rx_busy       (p_busy)
  );

  int          vectors = 0, miscompares = 0;
  logic [10:0] exp_d[$], exp_p[$];
  logic [7:0]  got_q[$];
  int          pops_d = 0, pops_p = 0, ovr_seen = 0, exp_ovr = 0;
  logic [10:0] last_d = '0, last_p = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line(input bit which, input logic v, input int n);
    if (which) rx_p = v; else rx_d = v;
    cyc(n);
  endtask

  task automatic send(input bit which, input logic [7:0] data, input bit has_par,
                      input logic par_bit, input logic stop_v);
    line(which, 1'b0, BT);
    for (int i = 0; i < 8; i++) line(which, data[i], BT);
    if (has_par) line(which, par_bit, BT);
    line(which, stop_v, BT);
    if (which) rx_p = 1'b1; else rx_d = 1'b1;
  endtask

  // Entry = {break, frame_err, parity_err, data}; parity DUT checks even parity.
  task automatic expect_frame(input bit which, input logic [7:0] data, input bit has_par,
                              input logic par_bit, input logic stop_v);
    logic perr, ferr;
    logic [10:0] ent;
    perr = has_par && (par_bit != ^data);
    ferr = !stop_v;
    ent  = {ferr && (data == 8'h00), ferr, perr, data};
    if (which) exp_p.push_back(ent);
    else if (exp_d.size() >= DEPTH) exp_ovr++;
    else exp_d.push_back(ent);
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_d.size() != 0 || exp_p.size() != 0) && n < budget) begin
      cyc(1);
      n++;
    end
    check(name, exp_d.size() + exp_p.size(), 0);
  endtask

  task automatic monitor();
    logic [10:0] g;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        g = {d_brk, d_ferr, d_perr, d_data};
        if (d_vld && exp_d.size() == 0) begin
          check("d_ghost_entry", {21'd0, g}, 32'hFFFF_FFFF);
        end else if (d_vld && d_rdy) begin
          check("d_entry", {21'd0, g}, {21'd0, exp_d.pop_front()});
          last_d = g;
          got_q.push_back(d_data);
          pops_d++;
        end
        if (d_ovr) ovr_seen++;
        g = {p_brk, p_ferr, p_perr, p_data};
        if (p_vld && exp_p.size() == 0) begin
          check("p_ghost_entry", {21'd0, g}, 32'hFFFF_FFFF);
        end else if (p_vld && p_rdy) begin
          check("p_entry", {21'd0, g}, {21'd0, exp_p.pop_front()});
          last_p = g;
          pops_p++;
        end
        if (p_ovr) check("p_overrun", 1, 0);
      end
    end
  endtask

  int p0, busy_cnt;

  initial begin
    rst_n = 1'b0;
    rx_d  = 1'b1;
    rx_p  = 1'b1;
    d_rdy = 1'b1;
    p_rdy = 1'b1;
    fork monitor(); join_none
    cyc(3);
    check("reset_outputs_d", {d_data, d_perr, d_ferr, d_brk, d_vld, d_ovr, d_busy}, 0);
    check("reset_outputs_p", {p_data, p_perr, p_ferr, p_brk, p_vld, p_ovr, p_busy}, 0);
    rst_n = 1'b1;
    cyc(5);

    fork
      begin
        p0 = pops_d;
        expect_frame(0, 8'h55, 0, 1'b0, 1'b1);
        send(0, 8'h55, 0, 1'b0, 1'b1);
        cyc(BT);
        check("t1_entry_55", last_d, 11'h055);
        check("t1_one_entry", pops_d - p0, 1);
        check("t1_no_overrun", ovr_seen, 0);
      end
      begin
        expect_frame(1, 8'hA3, 1, 1'b1, 1'b1);
        send(1, 8'hA3, 1, 1'b1, 1'b1);
        cyc(BT);
        check("par_bad_entry", last_p, 11'h1A3);
        expect_frame(1, 8'hA3, 1, 1'b0, 1'b1);
        send(1, 8'hA3, 1, 1'b0, 1'b1);
        cyc(BT);
        check("par_good_entry", last_p, 11'h0A3);
        check("par_entries", pops_p, 2);
      end
    join
    wait_empty("drain_t1", 100);

    expect_frame(0, 8'h3C, 0, 1'b0, 1'b0);
    send(0, 8'h3C, 0, 1'b0, 1'b0);
    cyc(BT);
    check("ferr_entry_3c", last_d, 11'h23C);
    check("ferr_idle_after_high", d_busy, 0);

    // all-zero data, stop held low for 20 bit times
    expect_frame(0, 8'h00, 0, 1'b0, 1'b0);
    p0 = pops_d;
    line(0, 1'b0, 29 * BT);
    check("break_busy_hold", d_busy, 1);
    check("break_single_entry", pops_d - p0, 1);
    check("break_entry", last_d, 11'h600);
    rx_d = 1'b1;
    cyc(BT);
    check("break_idle_after_high", d_busy, 0);
    check("break_no_more", pops_d - p0, 1);

    p0 = pops_d;
    busy_cnt = 0;
    rx_d = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (d_busy) busy_cnt++;
    end
    rx_d = 1'b1;
    cyc(400);
    check("glitch_busy_seen", busy_cnt > 0, 1);
    check("glitch_busy_clear", d_busy, 0);
    check("glitch_no_entry", {pops_d - p0, 31'd0} | d_vld, 0);

    d_rdy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) check("ovr_before_5", ovr_seen, 0);
      expect_frame(0, 8'(k), 0, 1'b0, 1'b1);
      send(0, 8'(k), 0, 1'b0, 1'b1);
    end
    cyc(5);
    check("ovr_once", ovr_seen, 1);
    check("ovr_model", ovr_seen, exp_ovr);
    check("full_head", {d_vld, d_data}, {1'b1, 8'h01});
    got_q.delete();
    d_rdy = 1'b1;
    wait_empty("drain_four", 50);
    check("drain_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) check("drain_order", got_q[i], i + 1);

    d_rdy = 1'b0;
    expect_frame(0, 8'h11, 0, 1'b0, 1'b1);
    send(0, 8'h11, 0, 1'b0, 1'b1);
    cyc(BT);
    check("pre_reset_valid", d_vld, 1);
    line(0, 1'b0, BT);
    for (int i = 0; i < 4; i++) line(0, 1'(8'h7E >> i), BT);
    rst_n = 1'b0;
    exp_d.delete();
    cyc(2);
    check("mid_reset_outputs_d", {d_data, d_perr, d_ferr, d_brk, d_vld, d_ovr, d_busy}, 0);
    check("mid_reset_outputs_p", {p_data, p_perr, p_ferr, p_brk, p_vld, p_ovr, p_busy}, 0);
    for (int i = 4; i < 8; i++) line(0, 1'(8'h7E >> i), BT);
    line(0, 1'b1, BT);
    check("late_reset_outputs_d", {d_data, d_perr, d_ferr, d_brk, d_vld, d_ovr, d_busy}, 0);
    rst_n = 1'b1;
    d_rdy = 1'b1;
    cyc(BT);
    p0 = pops_d;
    expect_frame(0, 8'h81, 0, 1'b0, 1'b1);
    send(0, 8'h81, 0, 1'b0, 1'b1);
    cyc(BT);
    wait_empty("drain_after_reset", 100);
    check("post_reset_entry", last_d, 11'h081);
    check("post_reset_count", pops_d - p0, 1);
    check("total_overruns", ovr_seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Synthesizable, parametrised UART receiver. Successor to the simulation-only monitor; it replaces `$display` with a valid/ready byte stream.
- Adds configurable data bits, parity and stop bits, 3-sample majority voting, false-start rejection, and error flags.
- A small elastic FIFO sits between the receiver and the consumer, which is a bus-side register block or a test harness.

Parameters:
- CLK_FREQUENCY, 50_000_000, clock frequency in Hz.
- BAUD_RATE, 115200, line rate in baud. BIT_TICKS = CLK_FREQUENCY/BAUD_RATE; must be ≥ 8.
- DATA_BITS, 8, data bits per frame; legal range 5..9, LSB first.
- PARITY_MODE, 0, parity setting: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- uart_rx  in  1  serial line, idle high, asynchronous to clk.
- rx_data  out  DATA_BITS  head-of-FIFO data.
- rx_parity_err  out  1  head entry had a parity mismatch.
- rx_frame_err  out  1  head entry had a stop bit sampled 0.
- rx_break  out  1  head entry was all-zero data with a framing error.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts the head entry.
- overrun_err  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
- rx_busy  out  1  receiver is not in IDLE.

Behaviour:
- Reset (async assert, sync deassert inside the block): state IDLE, FIFO empty, counters 0. All outputs 0. The synchronizer flops reset to 1 (line idle).
- Input sync: 2-flop synchronizer; the FSM sees rx_s, which lags uart_rx by 2 cycles.
- Majority vote: each bit value is the majority of rx_s at tick counts MID-1, MID and MID+1, where MID = BIT_TICKS/2. The bit is committed on the MID+1 cycle.
- IDLE:
  - On an rx_s 1→0 edge, go to START and load tick_cnt = 0. tick_cnt counts up 0..BIT_TICKS-1 in every non-IDLE state.
  - A line stuck low at reset exit does not start a frame; an observed high level is required first.
- START: at the vote point, a voted 1 is a false start; return to IDLE with no push. A voted 0 continues. At tick BIT_TICKS-1, go to DATA with bit_idx = 0.
- DATA:
  - Vote each bit into shift_reg[bit_idx].
  - At end of bit, bit_idx++.
  - After bit DATA_BITS-1, go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY: expected value = XOR of data, inverted for odd. perr = (voted != expected).
- STOP:
  - Vote each stop bit; any stop bit voted 0 sets ferr.
  - At the vote point of the last stop bit, push {break, ferr, perr, data} where break = ferr && data == 0.
  - Then go to IDLE immediately; no waiting for end of the stop bit, which permits back-to-back frames.
  - If ferr is set, go to WAIT_HIGH instead and stay until rx_s == 1, then IDLE. No new start is detected during a break.
- Push timing: rx_valid rises on the cycle after the push.
- FIFO rules:
  - Push is accepted if not full, or if a pop occurs in the same cycle.
  - Push into a full FIFO with no pop: the frame is discarded, FIFO contents are unchanged, overrun_err pulses for 1 cycle.
  - Pop when rx_valid && rx_ready.
  - Simultaneous push and pop on an empty FIFO: no pop (rx_valid is 0); push occurs.
  - Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- rx_data and the flag outputs are registered head-of-FIFO values. They are held stable while rx_valid && !rx_ready.
- Reset mid-frame: the frame is abandoned, the FIFO is flushed, and no push or pulse occurs.
- Elaboration checks: `$error` on illegal DATA_BITS, PARITY_MODE, STOP_BITS, FIFO_DEPTH, or BIT_TICKS < 8.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH}.
  - parity_mode constants PAR_NONE/PAR_EVEN/PAR_ODD.
  - Function bit_ticks(freq, baud).
- One sub-module: uart_rx_fifo. Parametrised WIDTH/DEPTH synchronous FIFO with push/pop, full/empty and count; async active-low reset.

Test Plan (default params, BIT_TICKS = 434):
- 8N1 frame 0x55, rx_ready = 1: one rx_valid pulse with rx_data = 0x55, all flags 0, overrun_err never asserted.
- PARITY_MODE = 1, frame 0xA3 sent with parity bit 1 (expected 0): entry with rx_data = 0xA3 and rx_parity_err = 1. Resending with parity bit 0 gives rx_parity_err = 0.
- 0x3C with stop bit driven 0, then line held high: rx_frame_err = 1, rx_break = 0. An all-zero frame with low stop held for 20 bit times gives a single entry with rx_break = 1 and no further entries until the line goes high.
- Low glitch of 100 cycles on an idle line: rx_busy pulses, then returns to 0; rx_valid is never asserted.
- rx_ready = 0 and five frames 0x01..0x05: FIFO holds 0x01..0x04. overrun_err pulses exactly once, at frame 5. Then rx_ready = 1 drains 0x01, 0x02, 0x03, 0x04 in order.
- rst_n asserted mid-DATA of frame 0x7E, then released and 0x81 sent: only 0x81 is delivered; all outputs read 0 during reset.
